// File: rtl/fetch_queue_if.sv
// Bus bundle for the fetch queue: pipeline control, memory request/response
// port and the decode-side head-of-queue port.
interface fetch_queue_if #(
   parameter int PTR_WIDTH = 2
);
   // pipeline control into fetch
   logic                 enable_fetch;
   logic                 stall;
   logic                 redirect;
   logic [31:0]          redirect_pc;
   // unified memory port
   logic [31:0]          mem_address;
   logic                 mem_rw;
   logic [1:0]           mem_access_size;
   logic                 mem_enable;
   logic                 mem_busy;
   logic [31:0]          mem_data_out;
   // decode port
   logic [31:0]          insn;
   logic [31:0]          pc_out;
   logic                 insn_valid;
   logic [PTR_WIDTH:0]   count;

   // master: the fetch queue itself
   modport master (
      input  enable_fetch, stall, redirect, redirect_pc, mem_busy, mem_data_out,
      output mem_address, mem_rw, mem_access_size, mem_enable,
             insn, pc_out, insn_valid, count
   );

   // slave: the surrounding pipeline and memory
   modport slave (
      output enable_fetch, stall, redirect, redirect_pc, mem_busy, mem_data_out,
      input  mem_address, mem_rw, mem_access_size, mem_enable,
             insn, pc_out, insn_valid, count
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: walks the PC, issues one-word reads, buffers
// returned words with their PCs in a small FIFO and hands them to decode.
// In-flight reads hold a FIFO credit, so a response always has a free slot.
module fetch_queue #(
   parameter int          DEPTH      = 4,
   parameter int          PTR_WIDTH  = 2,
   parameter logic [31:0] START_ADDR = 32'h80020000
) (
   input logic           clock,
   input logic           reset,
   fetch_queue_if.master bus
);
   localparam logic [PTR_WIDTH+1:0] DEPTH_CREDITS = (PTR_WIDTH+2)'(DEPTH);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE       = 1;
   localparam logic [PTR_WIDTH:0]   CNT_ONE       = 1;

   logic [31:0]          insn_mem [DEPTH];
   logic [31:0]          pc_mem   [DEPTH];
   logic [PTR_WIDTH-1:0] head;
   logic [PTR_WIDTH-1:0] tail;
   logic [PTR_WIDTH:0]   occupancy;
   logic                 inflight;
   logic [31:0]          inflight_pc;
   logic [31:0]          next_pc;

   logic [PTR_WIDTH+1:0] credits_used;
   logic                 fifo_valid;
   logic                 accept;
   logic                 enqueue;
   logic                 dequeue;

   // Request issue with credit check, plus head-of-queue presentation
   always_comb begin
      // NOTE: every signal driven here gets its value on all paths (defaults first), so no latch is inferred.
      credits_used        = {1'b0, occupancy} + {{(PTR_WIDTH+1){1'b0}}, inflight};
      fifo_valid          = (occupancy != '0);
      bus.mem_enable      = bus.enable_fetch & ~bus.redirect & ~reset
                            & (credits_used < DEPTH_CREDITS);
      bus.mem_address     = next_pc;
      bus.mem_rw          = 1'b1;
      bus.mem_access_size = 2'b00;
      accept              = bus.mem_enable & ~bus.mem_busy;
      // a redirect or reset discards the response arriving this cycle
      enqueue             = inflight & ~bus.redirect & ~reset;
      dequeue             = fifo_valid & ~bus.stall & ~bus.redirect & ~reset;
      bus.insn_valid      = fifo_valid;
      bus.count           = occupancy;
      bus.insn            = 32'h0;
      bus.pc_out          = 32'h0;
      if (fifo_valid) begin
         bus.insn   = insn_mem[head];
         bus.pc_out = pc_mem[head];
      end
   end

   // Control state: PC walk, in-flight tracking, pointers and occupancy
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         next_pc     <= START_ADDR;
         inflight    <= 1'b0;
         inflight_pc <= 32'h0;
         head        <= '0;
         tail        <= '0;
         occupancy   <= '0;
      end else if (bus.redirect) begin
         next_pc   <= {bus.redirect_pc[31:2], 2'b00};
         inflight  <= 1'b0;
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         // a fresh acceptance keeps the flag set for back-to-back reads
         inflight <= accept;
         if (accept) begin
            inflight_pc <= next_pc;
            next_pc     <= next_pc + 32'd4;
         end
         if (enqueue) tail <= tail + PTR_ONE;
         if (dequeue) head <= head + PTR_ONE;
         unique case ({enqueue, dequeue})
            2'b10:   occupancy <= occupancy + CNT_ONE;
            2'b01:   occupancy <= occupancy - CNT_ONE;
            default: ;
         endcase
      end
   end

   // FIFO storage: write the returning word and its PC at the tail
   always_ff @(posedge clock) begin
      // NOTE: storage is not reset; occupancy gates every read, so stale contents are never visible.
      if (enqueue) begin
         insn_mem[tail] <= bus.mem_data_out;
         pc_mem[tail]   <= inflight_pc;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based reference model,
// with directed phases for latency, stall saturation, busy, redirect,
// mid-stream reset and PC wrap.
module tb_fetch_queue;
   localparam int          DEPTH      = 4;
   localparam int          PTR_WIDTH  = 2;
   localparam logic [31:0] START_ADDR = 32'h80020000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fetch_queue_if #(.PTR_WIDTH(PTR_WIDTH)) bus ();

   fetch_queue #(
      .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH), .START_ADDR(START_ADDR)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.master)
   );

   always #5 clock = ~clock;

   // memory contents as a fixed function of the word address
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // memory: data one cycle after an accepted request, junk otherwise
   always @(posedge clock) begin
      if (bus.mem_enable && !bus.mem_busy) bus.mem_data_out <= mem_word(bus.mem_address);
      else                                 bus.mem_data_out <= $urandom;
   end

   // reference model: queue of PCs awaiting decode, one outstanding read
   logic [31:0] mq [$];
   bit          m_inflight = 1'b0;
   logic [31:0] m_inflight_pc;
   logic [31:0] m_next_pc;
   bit          m_known = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // one cycle: drive inputs, compare outputs with the model, advance the model
   task automatic step(input bit en, input bit st, input bit busy, input bit redir,
                       input bit rst, input logic [31:0] rpc);
      bit exp_en;
      @(negedge clock);
      bus.enable_fetch = en;
      bus.stall        = st;
      bus.mem_busy     = busy;
      bus.redirect     = redir;
      bus.redirect_pc  = rpc;
      reset            = rst;
      #1;
      exp_en = en && !redir && !rst && (mq.size() + int'(m_inflight) < DEPTH);
      check("mem_enable", bus.mem_enable, exp_en);
      if (m_known) begin
         check("mem_address", bus.mem_address, m_next_pc);
         check("mem_rw", bus.mem_rw, 1);
         check("mem_size", bus.mem_access_size, 0);
         check("count", bus.count, mq.size());
         check("insn_valid", bus.insn_valid, mq.size() > 0);
         check("pc_out", bus.pc_out, mq.size() > 0 ? mq[0] : 32'h0);
         check("insn", bus.insn, mq.size() > 0 ? mem_word(mq[0]) : 32'h0);
      end
      @(posedge clock);
      if (rst) begin
         mq.delete();
         m_inflight = 1'b0;
         m_next_pc  = START_ADDR;
         m_known    = 1'b1;
      end else if (redir) begin
         mq.delete();
         m_inflight = 1'b0;
         m_next_pc  = rpc & 32'hFFFFFFFC;
      end else begin
         if (mq.size() > 0 && !st) void'(mq.pop_front());
         if (m_inflight) mq.push_back(m_inflight_pc);
         m_inflight = exp_en && !busy;
         if (m_inflight) begin
            m_inflight_pc = m_next_pc;
            m_next_pc     = m_next_pc + 32'd4;
         end
      end
   endtask

   initial begin
      bus.enable_fetch = 1'b0;
      bus.stall        = 1'b0;
      bus.mem_busy     = 1'b0;
      bus.redirect     = 1'b0;
      bus.redirect_pc  = 32'h0;

      // reset state
      repeat (2) step(0, 0, 0, 0, 1, 0);
      #1;
      check("rst_count", bus.count, 0);
      check("rst_valid", bus.insn_valid, 0);
      check("rst_insn", bus.insn, 0);
      check("rst_pc_out", bus.pc_out, 0);

      // streaming: first valid two edges after enable
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      #1;
      check("lat_valid", bus.insn_valid, 1);
      check("lat_pc", bus.pc_out, START_ADDR);
      check("lat_insn", bus.insn, mem_word(START_ADDR));
      repeat (10) step(1, 0, 0, 0, 0, 0);

      // stall saturation, then contiguous release
      repeat (10) step(1, 1, 0, 0, 0, 0);
      #1;
      check("stall_count", bus.count, DEPTH);
      check("stall_req", bus.mem_enable, 0);
      repeat (10) step(1, 0, 0, 0, 0, 0);

      // memory busy mid-stream
      repeat (3) step(1, 0, 1, 0, 0, 0);
      repeat (6) step(1, 0, 0, 0, 0, 0);

      // redirect with three queued and one in flight
      step(0, 0, 0, 0, 1, 0);
      repeat (4) step(1, 1, 0, 0, 0, 0);
      #1;
      check("pre_redir_count", bus.count, 3);
      step(1, 0, 0, 1, 0, 32'h80020043);
      #1;
      check("redir_count", bus.count, 0);
      check("redir_valid", bus.insn_valid, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      #1;
      check("redir_pc", bus.pc_out, 32'h80020040);
      check("redir_insn", bus.insn, mem_word(32'h80020040));
      repeat (4) step(1, 0, 0, 0, 0, 0);

      // reset mid-stream with a read in flight
      step(1, 0, 0, 0, 1, 0);
      #1;
      check("mrst_count", bus.count, 0);
      check("mrst_valid", bus.insn_valid, 0);
      check("mrst_insn", bus.insn, 0);
      check("mrst_pc_out", bus.pc_out, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      #1;
      check("mrst_restart", bus.pc_out, START_ADDR);

      // PC wrap at the top of the address space
      step(1, 0, 0, 1, 0, 32'hFFFFFFF9);
      repeat (8) step(1, 0, 0, 0, 0, 0);

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) < 90, $urandom_range(99) < 30, $urandom_range(99) < 25,
              $urandom_range(99) < 3, $urandom_range(999) < 5, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
